cpu_datapath: RTL and testbench
===============================

Name: cpu_datapath

Overview:
- 32-bit single-bus CPU datapath: 16 general registers R0–R15, plus PC, HI, LO, Y, 64-bit Z, MAR, MDR and InPort.
- All transfers go over one shared 32-bit bus, driven by one source selected by the *out strobes.
- A combinational ALU computes Y op Bus into Z.
- An external control unit or bench sequences the strobes one step per clock.

Parameters:
- WIDTH, 32, data/bus width.
- NREGS, 16, number of general registers.

Ports:
- clock  in  1  system clock, rising-edge.
- clear  in  1  asynchronous reset, active-low.
- R0in..R15in  in  1 each  load general register n from bus.
- PCin, HIin, LOin, Yin, MARin, InPortIn  in  1 each  load that register from bus.
- MDRin  in  1  load MDR (source selected by read).
- read  in  1  MDR source select: 1 = Mdatain, 0 = bus.
- Zin  in  1  load 64-bit Z from ALU result.
- incPC  in  1  PC <= PC+1.
- opcode  in  5  ALU operation.
- Mdatain  in  32  memory data input.
- R0out..R15out, PCout, HIout, LOout, ZHighOut, ZLowOut, MDRout, InPortOut  in  1 each  drive bus.
- BusMuxOut  out  32  current bus value (observability).
- MARout  out  32  MAR contents (memory address).

Behaviour:
- Reset: clear low clears every register (R0–R15, PC, HI, LO, Y, Z, MAR, MDR, InPort) to 0 asynchronously, independent of clock.
- Loads: on rising clock edge, each register whose *in strobe is high captures its source.
- Multiple loads in one cycle are allowed.
- Bus: combinational mux.
  - Exactly one *out expected; if none, bus = 0.
  - If several, fixed priority: R0..R15, HI, LO, ZHigh, ZLow, PC, MDR, InPort (R0 highest).
- MDR: MDRin & read -> Mdatain; MDRin & !read -> bus.
- PC: incPC has priority over PCin in the same cycle; PC wraps 0xFFFFFFFF -> 0.
- ALU: A = Y, B = bus. Z captures {ZHigh, ZLow} on Zin.
- Opcodes; results go to ZLow with ZHigh = 0 unless stated:
  - 00011 add.
  - 00100 sub (A-B).
  - 00101 and.
  - 00110 or.
  - 00111 ror (A by B[4:0]).
  - 01000 rol (A by B[4:0]).
  - 01001 shr (logical).
  - 01010 shra (arithmetic).
  - 01011 shl.
  - 01110 mul: signed A*B, full 64 bits.
  - 01111 div: signed; ZLow = quotient, ZHigh = remainder.
  - 10000 neg (-B).
  - 10001 not (~B).
  - All others: Z = 0.
- Shift/rotate amounts use B[4:0] only; amount 0 returns A unchanged.
- add/sub wrap modulo 2^32; no flags.
- div by zero: Z = 0.
- div truncates toward zero; remainder takes the sign of the dividend.
- No handshake; latency of every transfer is one clock edge.
- ALU is fully combinational and settles within the cycle.
- Reset mid-operation wins over any simultaneous load.

Decomposition:
- Shared package cpu_pkg: WIDTH, opcode localparams (OP_ADD … OP_NOT, OP_ROL = 5'b01000), bus-source priority order.
- Sub-module cpu_alu: opcode, A, B -> 64-bit result.
- Registers as a generic reg32 with async active-low clear and enable.
- Bus mux inline.

Test Plan:
- Reset: load R5 = 0x1234, drop clear -> R5, PC, Z, MDR all read 0 on bus with no clock edge.
- ROL: Mdatain 0x0A via MDR into R4; 0x16 into R3; R4out+Yin; R3out+opcode 01000+Zin; ZLowOut+R7in -> R7 = 0x02800000.
- Fetch: PC = 0, PCout+MARin+incPC one cycle -> MARout = 0, PC = 1.
  - Then read+MDRin with Mdatain 0x8 -> MDRout drives 0x00000008.
- Arithmetic: Y = 0xFFFFFFFF, bus 0x00000001, add -> ZLow = 0, ZHigh = 0.
  - mul Y = -3, B = 7 -> Z = 0xFFFFFFFF_FFFFFFEB.
- div Y = -7, B = 2 -> ZLow = 0xFFFFFFFD (-3), ZHigh = 0xFFFFFFFF (-1).
  - B = 0 -> Z = 0.
- Bus priority/idle: no *out -> BusMuxOut = 0; R2out and MDRout together -> bus = R2.
  - shra 0x80000000 by 4 -> 0xF8000000; shr -> 0x08000000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, ALU opcodes and bus-source priority indices for the single-bus datapath.
// A lower source index means a higher priority on the shared bus.
package cpu_pkg;

  localparam int WIDTH = 32;
  localparam int NREGS = 16;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;

  // General registers occupy indices 0..NREGS-1
  localparam int SRC_HI     = NREGS;
  localparam int SRC_LO     = NREGS + 1;
  localparam int SRC_ZHIGH  = NREGS + 2;
  localparam int SRC_ZLOW   = NREGS + 3;
  localparam int SRC_PC     = NREGS + 4;
  localparam int SRC_MDR    = NREGS + 5;
  localparam int SRC_INPORT = NREGS + 6;
  localparam int NSRC       = NREGS + 7;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: result = A op B, 64 bits wide so mul/div can fill ZHigh.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result
);

  logic [4:0]                sh;
  logic [2*WIDTH-1:0]        dbl_a;
  logic [2*WIDTH-1:0]        rot_r;
  logic [2*WIDTH-1:0]        rot_l;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0]   quo;
  logic signed [WIDTH-1:0]   rem;

  // Rotates shift a doubled copy of A so amount 0 needs no special case
  assign sh    = b[4:0];
  assign dbl_a = {a, a};
  assign rot_r = dbl_a >> sh;
  assign rot_l = dbl_a << sh;
  assign prod  = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign quo   = $signed(a) / $signed(b);
  assign rem   = $signed(a) % $signed(b);

  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD:  result[WIDTH-1:0] = a + b;
      OP_SUB:  result[WIDTH-1:0] = a - b;
      OP_AND:  result[WIDTH-1:0] = a & b;
      OP_OR:   result[WIDTH-1:0] = a | b;
      OP_ROR:  result[WIDTH-1:0] = rot_r[WIDTH-1:0];
      OP_ROL:  result[WIDTH-1:0] = rot_l[2*WIDTH-1:WIDTH];
      OP_SHR:  result[WIDTH-1:0] = a >> sh;
      OP_SHRA: result[WIDTH-1:0] = $signed(a) >>> sh;
      OP_SHL:  result[WIDTH-1:0] = a << sh;
      OP_MUL:  result = prod;
      OP_DIV:  if (b != '0) result = {rem, quo};
      OP_NEG:  result[WIDTH-1:0] = WIDTH'(0) - b;
      OP_NOT:  result[WIDTH-1:0] = ~b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/reg32.sv
// Generic load-enabled register with asynchronous active-low clear.
module reg32 #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/cpu_datapath.sv
// Single-bus 32-bit CPU datapath: register file, special registers, ALU and
// a priority bus mux, all strobed one step per clock by an external sequencer.
module cpu_datapath
  import cpu_pkg::*;
(
  input  logic               clock,
  input  logic               clear,
  input  logic               R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic               R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic               PCin, HIin, LOin, Yin, MARin, InPortIn,
  input  logic               MDRin,
  input  logic               read,
  input  logic               Zin,
  input  logic               incPC,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   Mdatain,
  input  logic               R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic               R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic               PCout, HIout, LOout, ZHighOut, ZLowOut, MDRout, InPortOut,
  output logic [WIDTH-1:0]   BusMuxOut,
  output logic [WIDTH-1:0]   MARout
);

  logic [NREGS-1:0]   r_in;
  logic [NSRC-1:0]    out_sel;
  logic [WIDTH-1:0]   src_data [NSRC];
  logic [WIDTH-1:0]   gpr_reg  [NREGS];
  logic [WIDTH-1:0]   bus_next;
  logic [WIDTH-1:0]   pc_reg, pc_next, hi_reg, lo_reg, y_reg, mar_reg, mdr_reg, mdr_next, inport_reg;
  logic [WIDTH-1:0]   zhigh_reg, zlow_reg;
  logic [2*WIDTH-1:0] alu_result;

  assign r_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                 R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

  // Bit position equals source index in cpu_pkg
  assign out_sel = {InPortOut, MDRout, PCout, ZLowOut, ZHighOut, LOout, HIout,
                    R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_gpr
      reg32 #(.W(WIDTH)) u_gpr (
        .clock(clock), .clear(clear), .en(r_in[gi]), .d(bus_next), .q(gpr_reg[gi])
      );
      assign src_data[gi] = gpr_reg[gi];
    end
  endgenerate

  assign src_data[SRC_HI]     = hi_reg;
  assign src_data[SRC_LO]     = lo_reg;
  assign src_data[SRC_ZHIGH]  = zhigh_reg;
  assign src_data[SRC_ZLOW]   = zlow_reg;
  assign src_data[SRC_PC]     = pc_reg;
  assign src_data[SRC_MDR]    = mdr_reg;
  assign src_data[SRC_INPORT] = inport_reg;

  // Walk lowest priority first so the highest-priority asserted source wins
  always_comb begin
    bus_next = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (out_sel[i]) bus_next = src_data[i];
    end
  end

  assign pc_next  = incPC ? pc_reg + WIDTH'(1) : bus_next;
  assign mdr_next = read ? Mdatain : bus_next;

  reg32 #(.W(WIDTH)) u_pc     (.clock(clock), .clear(clear), .en(incPC | PCin), .d(pc_next),  .q(pc_reg));
  reg32 #(.W(WIDTH)) u_hi     (.clock(clock), .clear(clear), .en(HIin),         .d(bus_next), .q(hi_reg));
  reg32 #(.W(WIDTH)) u_lo     (.clock(clock), .clear(clear), .en(LOin),         .d(bus_next), .q(lo_reg));
  reg32 #(.W(WIDTH)) u_y      (.clock(clock), .clear(clear), .en(Yin),          .d(bus_next), .q(y_reg));
  reg32 #(.W(WIDTH)) u_mar    (.clock(clock), .clear(clear), .en(MARin),        .d(bus_next), .q(mar_reg));
  reg32 #(.W(WIDTH)) u_mdr    (.clock(clock), .clear(clear), .en(MDRin),        .d(mdr_next), .q(mdr_reg));
  reg32 #(.W(WIDTH)) u_inport (.clock(clock), .clear(clear), .en(InPortIn),     .d(bus_next), .q(inport_reg));
  reg32 #(.W(WIDTH)) u_zhigh  (.clock(clock), .clear(clear), .en(Zin),
                               .d(alu_result[2*WIDTH-1:WIDTH]), .q(zhigh_reg));
  reg32 #(.W(WIDTH)) u_zlow   (.clock(clock), .clear(clear), .en(Zin),
                               .d(alu_result[WIDTH-1:0]), .q(zlow_reg));

  cpu_alu u_alu (
    .opcode(opcode),
    .a(y_reg),
    .b(bus_next),
    .result(alu_result)
  );

  assign BusMuxOut = bus_next;
  assign MARout    = mar_reg;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench: stimulus pushes expected bus/MAR values into a scoreboard,
// a separate monitor pops and compares them mid-cycle or on demand.
module tb_cpu_datapath;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] rin = '0;
  logic [15:0] rout = '0;
  logic        pc_in = 0, hi_in = 0, lo_in = 0, y_in = 0, mar_in = 0, inport_in = 0;
  logic        mdr_in = 0, read = 0, z_in = 0, inc_pc = 0;
  logic        pc_out = 0, hi_out = 0, lo_out = 0, zhigh_out = 0, zlow_out = 0, mdr_out = 0, inport_out = 0;
  logic [4:0]  opcode = '0;
  logic [31:0] mdatain = '0;
  logic [31:0] bus, mar;

  typedef struct {
    string       name;
    logic [31:0] exp;
    bit          is_mar;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  event sample_ev;

  always #5 clock = ~clock;

  cpu_datapath dut (
    .clock(clock), .clear(clear),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .PCin(pc_in), .HIin(hi_in), .LOin(lo_in), .Yin(y_in), .MARin(mar_in), .InPortIn(inport_in),
    .MDRin(mdr_in), .read(read), .Zin(z_in), .incPC(inc_pc), .opcode(opcode), .Mdatain(mdatain),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .PCout(pc_out), .HIout(hi_out), .LOout(lo_out), .ZHighOut(zhigh_out), .ZLowOut(zlow_out),
    .MDRout(mdr_out), .InPortOut(inport_out),
    .BusMuxOut(bus), .MARout(mar)
  );

  // Monitor: drains the scoreboard at each falling edge or on an explicit sample request
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clock or sample_ev);
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = e.is_mar ? mar : bus;
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s: got=%08h want=%08h", e.name, act, e.exp);
        end else begin
          $display("ok   %s: %08h", e.name, act);
        end
      end
    end
  end

  task automatic expect_val(input string name, input logic [31:0] v, input bit is_mar = 0);
    exp_t e;
    e.name = name; e.exp = v; e.is_mar = is_mar;
    sb.push_back(e);
  endtask

  task automatic idle_strobes();
    rin = '0; rout = '0;
    pc_in = 0; hi_in = 0; lo_in = 0; y_in = 0; mar_in = 0; inport_in = 0;
    mdr_in = 0; read = 0; z_in = 0; inc_pc = 0; opcode = '0;
    pc_out = 0; hi_out = 0; lo_out = 0; zhigh_out = 0; zlow_out = 0; mdr_out = 0; inport_out = 0;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    idle_strobes();
  endtask

  task automatic mdr_load(input logic [31:0] v);
    mdatain = v; read = 1; mdr_in = 1;
    cyc();
  endtask

  task automatic set_y(input logic [31:0] v);
    mdr_load(v);
    mdr_out = 1; y_in = 1;
    cyc();
  endtask

  // B comes from MDR; then read back ZLow and ZHigh over the bus
  task automatic alu_check(input string name, input logic [4:0] op, input logic [31:0] b,
                           input logic [31:0] lo, input logic [31:0] hi);
    mdr_load(b);
    mdr_out = 1; opcode = op; z_in = 1;
    cyc();
    zlow_out = 1; expect_val({name, "_lo"}, lo);
    cyc();
    zhigh_out = 1; expect_val({name, "_hi"}, hi);
    cyc();
  endtask

  initial begin
    // Power-on reset state
    #3;
    expect_val("rst_bus", 32'h0);
    expect_val("rst_mar", 32'h0, 1);
    @(posedge clock); #1;
    clear = 1;

    // Make R5, PC, Z and MDR nonzero, then clear asynchronously
    mdr_load(32'h1234);
    mdr_out = 1; rin[5] = 1; inc_pc = 1; y_in = 1; z_in = 1; opcode = 5'b00011;
    expect_val("mdr_1234", 32'h1234);
    cyc();
    rout[5] = 1; expect_val("r5_loaded", 32'h1234);
    @(negedge clock); #1;
    clear = 0; #1;
    expect_val("rst_r5", 32'h0); -> sample_ev; #1;
    rout[5] = 0; pc_out = 1;
    expect_val("rst_pc", 32'h0); -> sample_ev; #1;
    pc_out = 0; zlow_out = 1;
    expect_val("rst_zlow", 32'h0); -> sample_ev; #1;
    zlow_out = 0; mdr_out = 1;
    expect_val("rst_mdr", 32'h0); -> sample_ev; #1;
    idle_strobes();
    @(posedge clock); #1;
    clear = 1;

    // ROL 0x0A by 0x16 through R4/R3 into R7
    mdr_load(32'h0A);
    mdr_out = 1; rin[4] = 1; cyc();
    mdr_load(32'h16);
    mdr_out = 1; rin[3] = 1; cyc();
    rout[4] = 1; y_in = 1; expect_val("r4", 32'h0A); cyc();
    rout[3] = 1; opcode = 5'b01000; z_in = 1; expect_val("r3", 32'h16); cyc();
    zlow_out = 1; rin[7] = 1; expect_val("rol_zlow", 32'h02800000); cyc();
    rout[7] = 1; expect_val("r7", 32'h02800000); cyc();

    // Fetch step
    pc_out = 1; mar_in = 1; inc_pc = 1; expect_val("pc0", 32'h0); cyc();
    expect_val("mar0", 32'h0, 1);
    pc_out = 1; expect_val("pc1", 32'h1); cyc();
    mdr_load(32'h8);
    mdr_out = 1; expect_val("mdr_fetch", 32'h8); cyc();

    // PC wrap, incPC beating PCin
    mdr_load(32'hFFFF_FFFF);
    mdr_out = 1; pc_in = 1; mar_in = 1; cyc();
    expect_val("mar_ff", 32'hFFFF_FFFF, 1);
    mdr_out = 1; pc_in = 1; inc_pc = 1; cyc();
    pc_out = 1; expect_val("pc_wrap", 32'h0); cyc();

    // Arithmetic
    set_y(32'hFFFF_FFFF);
    alu_check("add", 5'b00011, 32'h1, 32'h0, 32'h0);
    alu_check("sub", 5'b00100, 32'h1, 32'hFFFF_FFFE, 32'h0);
    set_y(32'hFFFF_FFFD);
    alu_check("mul", 5'b01110, 32'h7, 32'hFFFF_FFEB, 32'hFFFF_FFFF);
    set_y(32'hFFFF_FFF9);
    alu_check("div", 5'b01111, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    alu_check("div0", 5'b01111, 32'h0, 32'h0, 32'h0);
    set_y(32'h8000_0000);
    alu_check("shra", 5'b01010, 32'h4, 32'hF800_0000, 32'h0);
    alu_check("shr", 5'b01001, 32'h4, 32'h0800_0000, 32'h0);
    alu_check("ror", 5'b00111, 32'h24, 32'h0800_0000, 32'h0);
    alu_check("neg", 5'b10000, 32'h4, 32'hFFFF_FFFC, 32'h0);
    alu_check("bad_op", 5'b11111, 32'h4, 32'h0, 32'h0);

    // Bus idle and priority
    expect_val("bus_idle", 32'h0); cyc();
    mdr_load(32'h55);
    mdr_out = 1; rin[2] = 1; hi_in = 1; inport_in = 1; cyc();
    mdr_load(32'hAA);
    rout[2] = 1; mdr_out = 1; expect_val("prio_r2_mdr", 32'h55); cyc();
    hi_out = 1; mdr_out = 1; expect_val("prio_hi_mdr", 32'h55); cyc();
    inport_out = 1; expect_val("inport", 32'h55); cyc();

    // Wait, bounded, for the monitor to drain
    for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got=%0d pending want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
